// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - FFT core frame controller: config sequencing, input tlast generation, bin tagging, stats
// Config changes are only applied between input frames so a frame is never split.

module fft_frame_ctrl #(
  parameter int                     FFT_LEN     = 1024,
  parameter int                     RE_IM_WIDTH = 24,
  parameter int                     SCALE_WIDTH = 10,
  parameter logic [SCALE_WIDTH-1:0] DEF_SCALE   = 10'h2AB,
  parameter int                     CNT_WIDTH   = 16,
  localparam int                    IDX_W       = $clog2(FFT_LEN),
  localparam int                    CFG_W       = 8 * ((SCALE_WIDTH + 8) / 8),
  localparam int                    DW          = 2 * RE_IM_WIDTH
) (
  input  logic                   clk_50m,
  input  logic                   rst_n,
  input  logic                   cfg_inverse,
  input  logic [SCALE_WIDTH-1:0] cfg_scale,
  input  logic                   cfg_update,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [DW-1:0]          s_axis_tdata,
  output logic                   core_cfg_tvalid,
  input  logic                   core_cfg_tready,
  output logic [CFG_W-1:0]       core_cfg_tdata,
  output logic                   core_s_tvalid,
  input  logic                   core_s_tready,
  output logic [DW-1:0]          core_s_tdata,
  output logic                   core_s_tlast,
  input  logic                   core_m_tvalid,
  output logic                   core_m_tready,
  input  logic [DW-1:0]          core_m_tdata,
  input  logic                   core_m_tlast,
  input  logic                   core_ev_tlast_unexpected,
  input  logic                   core_ev_tlast_missing,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DW-1:0]          m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic [IDX_W-1:0]       m_axis_tuser,
  output logic                   cur_inverse,
  output logic [CNT_WIDTH-1:0]   frames_in,
  output logic [CNT_WIDTH-1:0]   frames_out,
  output logic [CNT_WIDTH-1:0]   err_cnt,
  output logic                   busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_LEN - 1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_SEND = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CFG_W-1:0]       tx_q, tx_d;
  logic                   pending_q, pending_d;
  logic                   sh_inv_q, sh_inv_d;
  logic [SCALE_WIDTH-1:0] sh_scale_q, sh_scale_d;
  logic                   cur_inv_q, cur_inv_d;
  logic [IDX_W-1:0]       in_cnt_q, in_cnt_d;
  logic [IDX_W-1:0]       out_cnt_q, out_cnt_d;
  logic [CNT_WIDTH-1:0]   frames_in_q, frames_in_d;
  logic [CNT_WIDTH-1:0]   frames_out_q, frames_out_d;
  logic [CNT_WIDTH-1:0]   err_q, err_d;

  logic gate;
  logic s_hs;
  logic m_hs;
  logic enter_send;
  logic err_ev;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Input is held off while a re-config waits at a frame boundary
  assign gate          = (state_q == ST_RUN) && !(pending_q && (in_cnt_q == '0));
  assign core_s_tvalid = s_axis_tvalid & gate;
  assign s_axis_tready = core_s_tready & gate;
  assign core_s_tdata  = s_axis_tdata;
  assign core_s_tlast  = (in_cnt_q == LAST_IDX);
  assign s_hs          = core_s_tvalid & core_s_tready;

  assign m_axis_tvalid = core_m_tvalid;
  assign core_m_tready = m_axis_tready;
  assign m_axis_tdata  = core_m_tdata;
  assign m_axis_tlast  = core_m_tlast;
  assign m_axis_tuser  = out_cnt_q;
  assign m_hs          = core_m_tvalid & m_axis_tready;

  assign core_cfg_tvalid = (state_q == ST_SEND);
  assign core_cfg_tdata  = tx_q;
  assign cur_inverse     = cur_inv_q;
  assign frames_in       = frames_in_q;
  assign frames_out      = frames_out_q;
  assign err_cnt         = err_q;
  assign busy            = (state_q != ST_RUN) || (in_cnt_q != '0);

  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    pending_d    = pending_q;
    sh_inv_d     = sh_inv_q;
    sh_scale_d   = sh_scale_q;
    cur_inv_d    = cur_inv_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    frames_in_d  = frames_in_q;
    frames_out_d = frames_out_q;
    err_d        = err_q;
    enter_send   = 1'b0;
    err_ev       = core_ev_tlast_unexpected | core_ev_tlast_missing;

    case (state_q)
      ST_INIT: begin
        state_d    = ST_SEND;
        enter_send = 1'b1;
      end
      ST_SEND: begin
        if (core_cfg_tready) begin
          state_d   = ST_RUN;
          cur_inv_d = ~tx_q[0];
        end
      end
      ST_RUN: begin
        if (pending_q && (in_cnt_q == '0)) begin
          state_d    = ST_SEND;
          enter_send = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase

    if (enter_send) begin
      tx_d                  = '0;
      tx_d[SCALE_WIDTH:1]   = sh_scale_q;
      tx_d[0]               = ~sh_inv_q;
      pending_d             = 1'b0;
    end

    // A same-cycle update wins over the clear, forcing a second SEND
    if (cfg_update) begin
      sh_inv_d   = cfg_inverse;
      sh_scale_d = cfg_scale;
      pending_d  = 1'b1;
    end

    if (s_hs) begin
      if (in_cnt_q == LAST_IDX) begin
        in_cnt_d    = '0;
        frames_in_d = sat_inc(frames_in_q);
      end else begin
        in_cnt_d = in_cnt_q + 1'b1;
      end
    end

    if (m_hs) begin
      if (core_m_tlast) begin
        out_cnt_d    = '0;
        frames_out_d = sat_inc(frames_out_q);
        if (out_cnt_q != LAST_IDX) err_ev = 1'b1;
      end else if (out_cnt_q == LAST_IDX) begin
        out_cnt_d = '0;
        err_ev    = 1'b1;
      end else begin
        out_cnt_d = out_cnt_q + 1'b1;
      end
    end

    if (err_ev) err_d = sat_inc(err_q);
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      tx_q         <= '0;
      pending_q    <= 1'b0;
      sh_inv_q     <= 1'b0;
      sh_scale_q   <= DEF_SCALE;
      cur_inv_q    <= 1'b0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      frames_in_q  <= '0;
      frames_out_q <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      pending_q    <= pending_d;
      sh_inv_q     <= sh_inv_d;
      sh_scale_q   <= sh_scale_d;
      cur_inv_q    <= cur_inv_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      frames_in_q  <= frames_in_d;
      frames_out_q <= frames_out_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb/tb_fft_frame_ctrl.sv - directed bench for fft_frame_ctrl
// Main instance uses defaults; a second small instance exercises counter saturation.

module tb_fft_frame_ctrl;

  logic        clk_50m = 1'b0;
  logic        rst_n;
  logic        cfg_inverse, cfg_update;
  logic [9:0]  cfg_scale;
  logic        s_axis_tvalid, s_axis_tready;
  logic [47:0] s_axis_tdata;
  logic        core_cfg_tvalid, core_cfg_tready;
  logic [15:0] core_cfg_tdata;
  logic        core_s_tvalid, core_s_tready;
  logic [47:0] core_s_tdata;
  logic        core_s_tlast;
  logic        core_m_tvalid, core_m_tready;
  logic [47:0] core_m_tdata;
  logic        core_m_tlast;
  logic        ev_u, ev_m;
  logic        m_axis_tvalid, m_axis_tready;
  logic [47:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic [9:0]  m_axis_tuser;
  logic        cur_inverse;
  logic [15:0] frames_in, frames_out, err_cnt;
  logic        busy;

  logic        ev2_u, ev2_m;
  logic        s_tready2, cfg_tvalid2, core_s_tvalid2, core_s_tlast2, core_m_tready2;
  logic        m_tvalid2, m_tlast2, cur_inv2, busy2;
  logic [15:0] cfg_tdata2;
  logic [47:0] core_s_tdata2, m_tdata2;
  logic [2:0]  m_tuser2;
  logic [1:0]  frames_in2, frames_out2, err2;

  int n_vec = 0;
  int n_err = 0;
  int cnt_a, cnt_b;

  always #10 clk_50m = ~clk_50m;

  fft_frame_ctrl dut (
    .clk_50m(clk_50m), .rst_n(rst_n),
    .cfg_inverse(cfg_inverse), .cfg_scale(cfg_scale), .cfg_update(cfg_update),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .core_cfg_tvalid(core_cfg_tvalid), .core_cfg_tready(core_cfg_tready), .core_cfg_tdata(core_cfg_tdata),
    .core_s_tvalid(core_s_tvalid), .core_s_tready(core_s_tready), .core_s_tdata(core_s_tdata),
    .core_s_tlast(core_s_tlast),
    .core_m_tvalid(core_m_tvalid), .core_m_tready(core_m_tready), .core_m_tdata(core_m_tdata),
    .core_m_tlast(core_m_tlast),
    .core_ev_tlast_unexpected(ev_u), .core_ev_tlast_missing(ev_m),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .cur_inverse(cur_inverse), .frames_in(frames_in), .frames_out(frames_out),
    .err_cnt(err_cnt), .busy(busy)
  );

  fft_frame_ctrl #(.FFT_LEN(8), .CNT_WIDTH(2)) dut_sat (
    .clk_50m(clk_50m), .rst_n(rst_n),
    .cfg_inverse(1'b0), .cfg_scale(10'd0), .cfg_update(1'b0),
    .s_axis_tvalid(1'b0), .s_axis_tready(s_tready2), .s_axis_tdata(48'd0),
    .core_cfg_tvalid(cfg_tvalid2), .core_cfg_tready(1'b0), .core_cfg_tdata(cfg_tdata2),
    .core_s_tvalid(core_s_tvalid2), .core_s_tready(1'b0), .core_s_tdata(core_s_tdata2),
    .core_s_tlast(core_s_tlast2),
    .core_m_tvalid(1'b0), .core_m_tready(core_m_tready2), .core_m_tdata(48'd0),
    .core_m_tlast(1'b0),
    .core_ev_tlast_unexpected(ev2_u), .core_ev_tlast_missing(ev2_m),
    .m_axis_tvalid(m_tvalid2), .m_axis_tready(1'b1), .m_axis_tdata(m_tdata2),
    .m_axis_tlast(m_tlast2), .m_axis_tuser(m_tuser2),
    .cur_inverse(cur_inv2), .frames_in(frames_in2), .frames_out(frames_out2),
    .err_cnt(err2), .busy(busy2)
  );

  task automatic tick();
    @(posedge clk_50m);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_inverse = 1'b0; cfg_update = 1'b0; cfg_scale = 10'd0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    core_cfg_tready = 1'b0; core_s_tready = 1'b1;
    core_m_tvalid = 1'b0; core_m_tdata = '0; core_m_tlast = 1'b0;
    ev_u = 1'b0; ev_m = 1'b0; ev2_u = 1'b0; ev2_m = 1'b0;
    m_axis_tready = 1'b1;

    tick(); tick(); #1;
    chk("rst_cfg_tvalid", core_cfg_tvalid, 0);
    chk("rst_cfg_tdata", core_cfg_tdata, 0);
    chk("rst_cur_inverse", cur_inverse, 0);
    chk("rst_frames_in", frames_in, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_busy", busy, 1);

    // Config send with 3 cycles of back-pressure
    rst_n = 1'b1;
    tick(); #1;
    chk("send_c1_valid", core_cfg_tvalid, 1);
    chk("send_c1_tdata", core_cfg_tdata, 16'h0557);
    chk("send_c1_s_tready", s_axis_tready, 0);
    tick(); #1;
    chk("send_c2_valid", core_cfg_tvalid, 1);
    tick(); #1;
    chk("send_c3_valid", core_cfg_tvalid, 1);
    chk("send_c3_tdata", core_cfg_tdata, 16'h0557);
    core_cfg_tready = 1'b1; #1;
    chk("send_c4_valid", core_cfg_tvalid, 1);
    tick(); #1;
    chk("run_cfg_valid", core_cfg_tvalid, 0);
    chk("run_cur_inverse", cur_inverse, 0);
    chk("run_busy", busy, 0);
    chk("run_s_tready", s_axis_tready, 1);

    // Two back-to-back frames
    cnt_a = 0; cnt_b = 0;
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 2048; k++) begin
      s_axis_tdata = 48'(k * 7 + 3);
      #1;
      if (core_s_tlast) cnt_a++;
      if (core_s_tlast !== ((k % 1024) == 1023)) cnt_b++;
      if (k == 5) chk("s_tdata_pass", core_s_tdata, 48'd38);
      if (k == 1023) chk("s_tlast_1023", core_s_tlast, 1);
      if (k == 2047) chk("s_tlast_2047", core_s_tlast, 1);
      tick();
    end
    s_axis_tvalid = 1'b0; #1;
    chk("s_tlast_count", 64'(cnt_a), 2);
    chk("s_tlast_pos_errs", 64'(cnt_b), 0);
    chk("frames_in_2", frames_in, 2);
    chk("idle_busy", busy, 0);

    // Re-config requested mid-frame at in_cnt = 500
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 500; k++) begin
      #1; tick();
    end
    cfg_update = 1'b1; cfg_inverse = 1'b1; cfg_scale = 10'd0;
    cnt_a = 0;
    for (int k = 0; k < 524; k++) begin
      #1;
      if (!s_axis_tready) cnt_a++;
      if (k == 523) chk("recfg_tlast", core_s_tlast, 1);
      tick();
      cfg_update = 1'b0;
    end
    #1;
    chk("recfg_no_stall", 64'(cnt_a), 0);
    chk("recfg_gate_ready", s_axis_tready, 0);
    chk("recfg_gate_valid", core_s_tvalid, 0);
    chk("recfg_frames_in", frames_in, 3);
    tick(); #1;
    chk("recfg_cfg_valid", core_cfg_tvalid, 1);
    chk("recfg_cfg_tdata", core_cfg_tdata, 16'h0000);
    tick(); #1;
    chk("recfg_cur_inverse", cur_inverse, 1);
    chk("recfg_cfg_done", core_cfg_tvalid, 0);
    chk("recfg_resume", s_axis_tready, 1);
    for (int k = 0; k < 1024; k++) begin
      #1;
      if (k == 1022) chk("resume_tlast_1022", core_s_tlast, 0);
      if (k == 1023) chk("resume_tlast_1023", core_s_tlast, 1);
      tick();
    end
    s_axis_tvalid = 1'b0; #1;
    chk("frames_in_4", frames_in, 4);

    // Output tagging: aligned frame, short frame, then a missing tlast
    core_m_tvalid = 1'b1;
    cnt_a = 0;
    for (int k = 0; k < 1024; k++) begin
      core_m_tdata = 48'(k + 100);
      core_m_tlast = (k == 1023);
      #1;
      if (m_axis_tuser !== 10'(k)) cnt_a++;
      if (k == 0) chk("m_tdata_pass", m_axis_tdata, 48'd100);
      if (k == 1023) chk("m_tuser_1023", m_axis_tuser, 1023);
      if (k == 1023) chk("m_tlast_pass", m_axis_tlast, 1);
      tick();
    end
    #1;
    chk("m_tuser_seq1", 64'(cnt_a), 0);
    chk("frames_out_1", frames_out, 1);
    chk("err_aligned", err_cnt, 0);
    cnt_a = 0;
    for (int k = 0; k < 701; k++) begin
      core_m_tlast = (k == 700);
      #1;
      if (m_axis_tuser !== 10'(k)) cnt_a++;
      tick();
    end
    core_m_tlast = 1'b0; #1;
    chk("m_tuser_seq2", 64'(cnt_a), 0);
    chk("frames_out_2", frames_out, 2);
    chk("err_short_frame", err_cnt, 1);
    chk("m_tuser_restart", m_axis_tuser, 0);
    tick();
    for (int k = 0; k < 1023; k++) begin
      #1; tick();
    end
    #1;
    chk("err_missing_tlast", err_cnt, 2);
    chk("frames_out_hold", frames_out, 2);
    chk("m_tuser_wrap", m_axis_tuser, 0);
    core_m_tvalid = 1'b0;
    m_axis_tready = 1'b0; #1;
    chk("m_tready_pass", core_m_tready, 0);
    m_axis_tready = 1'b1;

    // Event counting and saturation on the 2-bit instance
    ev2_u = 1'b1; ev2_m = 1'b1; tick(); ev2_u = 1'b0; ev2_m = 1'b0; #1;
    chk("sat_both", err2, 1);
    ev2_u = 1'b1; tick(); ev2_u = 1'b0; #1;
    chk("sat_unexp", err2, 2);
    ev2_m = 1'b1; tick(); ev2_m = 1'b0; #1;
    chk("sat_missing", err2, 3);
    ev2_u = 1'b1; ev2_m = 1'b1; tick(); ev2_u = 1'b0; ev2_m = 1'b0; #1;
    chk("sat_hold", err2, 3);
    chk("main_err_isolated", err_cnt, 2);

    // Reset mid-frame
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      #1; tick();
    end
    #1; rst_n = 1'b0; #1;
    chk("arst_cfg_valid", core_cfg_tvalid, 0);
    chk("arst_cfg_tdata", core_cfg_tdata, 0);
    chk("arst_s_tvalid", core_s_tvalid, 0);
    chk("arst_s_tready", s_axis_tready, 0);
    chk("arst_frames_in", frames_in, 0);
    chk("arst_frames_out", frames_out, 0);
    chk("arst_err", err_cnt, 0);
    chk("arst_cur_inverse", cur_inverse, 0);
    chk("arst_tlast", core_s_tlast, 0);
    chk("arst_busy", busy, 1);
    tick();
    rst_n = 1'b1;
    tick(); #1;
    chk("rerst_cfg_valid", core_cfg_tvalid, 1);
    chk("rerst_cfg_tdata", core_cfg_tdata, 16'h0557);
    tick(); #1;
    chk("rerst_cur_inverse", cur_inverse, 0);
    chk("rerst_busy", busy, 0);
    chk("rerst_tlast", core_s_tlast, 0);
    s_axis_tvalid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Frame controller between a raw sample stream and the FFT core's AXI-Stream ports.
- Generates the core config word, with run-time forward/inverse and scaling, and re-sends it only at frame boundaries.
- Generates input tlast from a sample counter, tags output bins with an index, and keeps frame and error statistics.
- Sits between the ADC/windowing front-end and the spectrum post-processing; the core instance lives outside this block.

Parameters:
FFT_LEN, 1024, points per frame (power of two, >=8)
RE_IM_WIDTH, 24, width of each of Re and Im
SCALE_WIDTH, 10, scaling-schedule field width
DEF_SCALE, 10'h2AB, scaling schedule applied after reset
CNT_WIDTH, 16, width of statistics counters
Derived: IDX_W = log2(FFT_LEN); CFG_W = 8*ceil((1+SCALE_WIDTH)/8), which is 16 at defaults.

Ports:
clk_50m  in  1  clock
rst_n  in  1  asynchronous, active-low reset
cfg_inverse  in  1  1 = inverse FFT requested
cfg_scale  in  SCALE_WIDTH  requested scaling schedule
cfg_update  in  1  one-cycle pulse; capture cfg_inverse/cfg_scale and schedule a re-config
s_axis_tvalid / s_axis_tready  in / out  1 / 1  sample stream handshake
s_axis_tdata  in  2*RE_IM_WIDTH  {Re,Im}
core_cfg_tvalid / core_cfg_tready  out / in  1 / 1  core config channel
core_cfg_tdata  out  CFG_W  {zero pad, scale, fwd}; bit0 = 1 means forward
core_s_tvalid / core_s_tready  out / in  1 / 1  core data-in handshake
core_s_tdata  out  2*RE_IM_WIDTH  equals s_axis_tdata
core_s_tlast  out  1  generated frame end
core_m_tvalid / core_m_tready  in / out  1 / 1  core data-out handshake
core_m_tdata / core_m_tlast  in  2*RE_IM_WIDTH / 1  core result
core_ev_tlast_unexpected, core_ev_tlast_missing  in  1 each  core event pulses
m_axis_tvalid / m_axis_tready  out / in  1 / 1  result handshake
m_axis_tdata / m_axis_tlast  out  2*RE_IM_WIDTH / 1  pass-through of core_m
m_axis_tuser  out  IDX_W  bin index of the current beat
cur_inverse  out  1  direction currently loaded in the core
frames_in, frames_out, err_cnt  out  CNT_WIDTH each  statistics
busy  out  1  high when state != RUN or in_cnt != 0

Behaviour:
- Reset (async) values:
  - state = INIT; all counters = 0; pending = 0; cur_inverse = 0.
  - Shadow registers: inverse = 0, scale = DEF_SCALE.
  - core_cfg_tvalid = 0; core_cfg_tdata = 0.
- States:
  - INIT -> SEND unconditionally on the first clock after reset release.
  - SEND:
    - On entry: load tx register = {pad, shadow scale, ~shadow inverse} and clear pending.
    - Hold core_cfg_tvalid = 1 with tdata stable until core_cfg_tready.
    - On the config handshake: cur_inverse <= tx inverse; go to RUN.
  - RUN -> SEND when pending = 1 and in_cnt = 0.
- cfg_update:
  - Captured in any state: shadow registers <= inputs; pending <= 1.
  - An update in the same cycle as SEND entry keeps pending = 1, so a second SEND follows.
- Input gate:
  - gate = (state == RUN) && !(pending && in_cnt == 0).
  - Combinational: core_s_tvalid = s_axis_tvalid & gate; s_axis_tready = core_s_tready & gate.
  - Data path has zero latency.
- Input counter:
  - in_cnt increments on each core_s handshake and wraps FFT_LEN-1 -> 0.
  - core_s_tlast = (in_cnt == FFT_LEN-1).
  - On the wrap, frames_in increments.
  - A re-config therefore never splits a frame.
- Output path:
  - m_axis_tvalid = core_m_tvalid; core_m_tready = m_axis_tready; tdata/tlast pass through.
  - m_axis_tuser = out_cnt.
  - out_cnt increments on each handshake.
- Output frame end:
  - On a handshake with core_m_tlast = 1: out_cnt <= 0 and frames_out increments.
  - If out_cnt != FFT_LEN-1 at that point, err_cnt also increments (misaligned frame).
  - A handshake with out_cnt == FFT_LEN-1 and tlast = 0 increments err_cnt; out_cnt then wraps to 0.
- Error events: each cycle with core_ev_tlast_unexpected or core_ev_tlast_missing high increments err_cnt by 1. Simultaneous error sources in one cycle count once.
- Counters saturate at all-ones and never wrap.
- Reset mid-frame or mid-SEND aborts immediately; after release the block re-sends the config with the reset defaults.

Test Plan:
- Release reset, hold core_cfg_tready = 0 for 3 cycles, then 1 -> core_cfg_tvalid rises the cycle after INIT and stays high 4 cycles; tdata = 16'h0557; state RUN; cur_inverse = 0.
- Stream 2*FFT_LEN samples with s_axis_tvalid always high -> core_s_tlast on beats 1023 and 2047; frames_in = 2; busy = 0 at the end.
- Pulse cfg_update (inverse = 1, scale = 0) at in_cnt = 500 -> samples continue until in_cnt wraps; s_axis_tready then drops; config tdata = 16'h0000; cur_inverse = 1; streaming resumes at in_cnt = 0.
- Drive core_m frames with tlast at beat 1023, then at beat 700 -> m_axis_tuser counts 0..1023; frames_out = 2; err_cnt = 1; next frame's tuser restarts at 0.
- Pulse core_ev_tlast_missing and core_ev_tlast_unexpected together, then each alone, with CNT_WIDTH = 2 -> err_cnt = 1, 2, 3, then saturates at 3 on a fourth event.
- Assert rst_n low at in_cnt = 300 -> all outputs return to reset values asynchronously; after release in_cnt = 0 and SEND repeats with DEF_SCALE and forward.
